// File: rtl/buzzer_arbiter.sv
// Quiz-round buzzer front end: synchronises and debounces four player buttons,
// grants the first press with a rotating priority, and snapshots the winner's switches.
module buzzer_arbiter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 0,
   parameter int CNT_W           = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  btn,
   input  logic [31:0] sw_all,
   input  logic        arm,
   input  logic        ack,
   output logic        armed,
   output logic        input_valid,
   output logic [1:0]  first_player,
   output logic [7:0]  switch_value,
   output logic        timeout
);

   localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURED
   } state_t;

   logic [3:0]  btn_meta_reg;
   logic [3:0]  btn_sync_reg;
   logic [31:0] sw_meta_reg;
   logic [31:0] sw_sync_reg;
   logic [3:0]  press;
   logic [7:0]  sw_slice [4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_meta_reg <= '0;
         btn_sync_reg <= '0;
         sw_meta_reg  <= '0;
         sw_sync_reg  <= '0;
      end else begin
         btn_meta_reg <= btn;
         btn_sync_reg <= btn_meta_reg;
         sw_meta_reg  <= sw_all;
         sw_sync_reg  <= sw_meta_reg;
      end
   end

   // Per-player debouncer; press_reg is a registered one-cycle rising-edge pulse
   // of the debounced level, so the FSM reacts one edge after the level flips.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_player
         logic [DB_W-1:0] cnt_reg;
         logic [DB_W-1:0] cnt_next;
         logic            level_reg;
         logic            level_next;
         logic            press_reg;

         always_comb begin
            cnt_next   = '0;
            level_next = level_reg;
            if (btn_sync_reg[gi] != level_reg) begin
               if (cnt_reg == DB_LAST) begin
                  level_next = ~level_reg;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
            end else begin
               cnt_reg   <= cnt_next;
               level_reg <= level_next;
               press_reg <= level_next & ~level_reg;
            end
         end

         assign press[gi]    = press_reg;
         assign sw_slice[gi] = sw_sync_reg[8*gi +: 8];
      end
   endgenerate

   // First requester at or above the pointer, wrapping 3 -> 0.
   function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      pick_winner = ptr;
      found       = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            pick_winner = idx;
            found       = 1'b1;
         end
      end
   endfunction

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] tmo_cnt_reg;
   logic [CNT_W-1:0] tmo_cnt_next;
   logic [1:0]       ptr_reg;
   logic [1:0]       ptr_next;
   logic [1:0]       first_player_reg;
   logic [1:0]       first_player_next;
   logic [7:0]       switch_value_reg;
   logic [7:0]       switch_value_next;
   logic             timeout_reg;
   logic             timeout_next;
   logic [1:0]       winner;

   assign winner = pick_winner(press, ptr_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         tmo_cnt_reg      <= '0;
         ptr_reg          <= '0;
         first_player_reg <= '0;
         switch_value_reg <= '0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         tmo_cnt_reg      <= tmo_cnt_next;
         ptr_reg          <= ptr_next;
         first_player_reg <= first_player_next;
         switch_value_reg <= switch_value_next;
         timeout_reg      <= timeout_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      tmo_cnt_next      = tmo_cnt_reg;
      ptr_next          = ptr_reg;
      first_player_next = first_player_reg;
      switch_value_next = switch_value_reg;
      timeout_next      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (arm) begin
               state_next   = ST_ARMED;
               tmo_cnt_next = '0;
            end
         end
         ST_ARMED: begin
            // A press on the expiry edge still wins over the timeout.
            if (|press) begin
               state_next        = ST_CAPTURED;
               first_player_next = winner;
               switch_value_next = sw_slice[winner];
               ptr_next          = winner + 2'd1;
            end else if (TMO_EN && (tmo_cnt_reg == TMO_LAST)) begin
               state_next   = ST_IDLE;
               timeout_next = 1'b1;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end
         ST_CAPTURED: begin
            if (ack) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign armed        = (state_reg == ST_ARMED);
   assign input_valid  = (state_reg == ST_CAPTURED);
   assign first_player = first_player_reg;
   assign switch_value = switch_value_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter: directed scenarios plus randomized rounds whose outcome
// is predicted from press times, the debounce latency and the rotating priority rule.
module tb_buzzer_arbiter;

   localparam int DB  = 16;
   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  btn;
   logic [31:0] sw_all;
   logic        arm;
   logic        ack;
   logic        armed;
   logic        input_valid;
   logic [1:0]  first_player;
   logic [7:0]  switch_value;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;
   int edge_n;
   int ptr_model;
   int last_fp;
   int last_sw;

   always #5 clk = ~clk;

   buzzer_arbiter #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn),
      .sw_all      (sw_all),
      .arm         (arm),
      .ack         (ack),
      .armed       (armed),
      .input_valid (input_valid),
      .first_player(first_player),
      .switch_value(switch_value),
      .timeout     (timeout)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      edge_n = 0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic release_all();
      btn = 4'b0000;
      repeat (DB + 10) tick();
   endtask

   // Advances edges after the arm edge; button i is driven high for on_at <= n < off_at
   // (left untouched when on_at < 0). Stops at the first capture or timeout.
   task automatic run_round(input int on_at[4], input int off_at[4], input int max_steps,
                            output int n_iv, output int n_to, output bit armed_ok);
      int n;
      n_iv = -1;
      n_to = -1;
      armed_ok = 1'b1;
      for (int s = 0; s < max_steps; s++) begin
         n = edge_n + 1;
         for (int i = 0; i < 4; i++)
            if (on_at[i] >= 0)
               btn[i] = (n >= on_at[i]) && (off_at[i] < 0 || n < off_at[i]);
         tick();
         edge_n = n;
         if (input_valid === 1'b1) begin
            n_iv = n;
            break;
         end
         if (timeout === 1'b1) begin
            n_to = n;
            break;
         end
         if (armed !== 1'b1) armed_ok = 1'b0;
      end
   endtask

   function automatic int model_winner(input bit [3:0] tied, input int ptr);
      for (int k = 0; k < 4; k++)
         if (tied[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic test_reset();
      reset = 1'b1; btn = '0; sw_all = '0; arm = 1'b0; ack = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      ptr_model = 0; last_fp = 0; last_sw = 0;
      n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0", armed); end
      n_cmp++; if (input_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", input_valid); end
      n_cmp++; if (first_player !== 2'd0) begin n_err++; $display("FAIL reset_fp: got %0d want 0", first_player); end
      n_cmp++; if (switch_value !== 8'h00) begin n_err++; $display("FAIL reset_sw: got %h want 00", switch_value); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      $display("reset: outputs checked");
   endtask

   task automatic test_simultaneous();
      int on[4], off[4];
      int n_iv, n_to, exp_fp;
      bit aok;
      for (int r = 0; r < 2; r++) begin
         exp_fp = (r == 0) ? 1 : 3;
         sw_all = $urandom;
         on = '{-1, 1, -1, 1};
         off = '{-1, -1, -1, -1};
         do_arm();
         run_round(on, off, 60, n_iv, n_to, aok);
         $display("simultaneous round %0d: valid at %0d, fp=%0d sw=%h", r, n_iv, first_player, switch_value);
         n_cmp++; if (n_iv !== 1 + DB + 2) begin n_err++; $display("FAIL simul_latency: got %0d want %0d", n_iv, 1 + DB + 2); end
         n_cmp++; if (first_player !== 2'(exp_fp)) begin n_err++; $display("FAIL simul_fp: got %0d want %0d", first_player, exp_fp); end
         n_cmp++; if (switch_value !== sw_all[8*exp_fp +: 8]) begin n_err++; $display("FAIL simul_sw: got %h want %h", switch_value, sw_all[8*exp_fp +: 8]); end
         last_fp = exp_fp; last_sw = int'(sw_all[8*exp_fp +: 8]); ptr_model = (exp_fp + 1) % 4;
         do_ack();
         release_all();
      end
   endtask

   task automatic test_basic();
      int on[4], off[4];
      int n_iv, n_to;
      bit aok;
      sw_all = 32'h1234_56A5;
      on = '{1, -1, -1, -1};
      off = '{31, -1, -1, -1};
      do_arm();
      run_round(on, off, 40, n_iv, n_to, aok);
      $display("basic: valid at %0d, fp=%0d sw=%h", n_iv, first_player, switch_value);
      n_cmp++; if (n_iv !== 19) begin n_err++; $display("FAIL basic_latency: got %0d want 19", n_iv); end
      n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL basic_armed: got %b want 1", aok); end
      n_cmp++; if (first_player !== 2'd0) begin n_err++; $display("FAIL basic_fp: got %0d want 0", first_player); end
      n_cmp++; if (switch_value !== 8'hA5) begin n_err++; $display("FAIL basic_sw: got %h want a5", switch_value); end
      do_ack();
      n_cmp++; if (input_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack_valid: got %b want 0", input_valid); end
      n_cmp++; if (switch_value !== 8'hA5) begin n_err++; $display("FAIL basic_hold_sw: got %h want a5", switch_value); end
      last_fp = 0; last_sw = 'hA5; ptr_model = 1;
      release_all();
   endtask

   task automatic test_glitch();
      int on[4], off[4];
      int n_iv, n_to;
      bit aok;
      on = '{-1, -1, 1, -1};
      off = '{-1, -1, 11, -1};
      do_arm();
      run_round(on, off, 60, n_iv, n_to, aok);
      $display("glitch: valid at %0d, timeout at %0d, armed=%b", n_iv, n_to, armed);
      n_cmp++; if (n_iv !== -1) begin n_err++; $display("FAIL glitch_capture: got %0d want -1", n_iv); end
      n_cmp++; if (armed !== 1'b1 || aok !== 1'b1) begin n_err++; $display("FAIL glitch_armed: got %b/%b want 1/1", armed, aok); end
      on = '{-1, -1, -1, -1};
      run_round(on, off, 60, n_iv, n_to, aok);
      n_cmp++; if (n_to !== TMO) begin n_err++; $display("FAIL glitch_timeout: got %0d want %0d", n_to, TMO); end
      release_all();
   endtask

   task automatic test_timeout();
      int on[4], off[4];
      int n_iv, n_to;
      bit aok;
      on = '{-1, -1, -1, -1};
      off = '{-1, -1, -1, -1};
      do_arm();
      run_round(on, off, TMO + 10, n_iv, n_to, aok);
      $display("timeout: pulse at %0d, armed=%b valid=%b", n_to, armed, input_valid);
      n_cmp++; if (n_to !== TMO) begin n_err++; $display("FAIL timeout_edge: got %0d want %0d", n_to, TMO); end
      n_cmp++; if (armed !== 1'b0 || input_valid !== 1'b0) begin n_err++; $display("FAIL timeout_state: got armed=%b valid=%b want 0/0", armed, input_valid); end
      n_cmp++; if (first_player !== 2'(last_fp)) begin n_err++; $display("FAIL timeout_hold_fp: got %0d want %0d", first_player, last_fp); end
      tick();
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_width: got %b want 0", timeout); end
   endtask

   task automatic test_held();
      int on[4], off[4];
      int n_iv, n_to;
      bit aok;
      btn = 4'b0001;
      repeat (DB + 10) tick();
      on = '{0, -1, -1, -1};
      off = '{31, -1, -1, -1};
      do_arm();
      run_round(on, off, 50, n_iv, n_to, aok);
      n_cmp++; if (n_iv !== -1 || aok !== 1'b1) begin n_err++; $display("FAIL held_no_capture: got valid at %0d armed_ok=%b want -1/1", n_iv, aok); end
      on = '{51, -1, -1, -1};
      off = '{-1, -1, -1, -1};
      run_round(on, off, 40, n_iv, n_to, aok);
      $display("held: re-press valid at %0d, fp=%0d", n_iv, first_player);
      n_cmp++; if (n_iv !== 51 + DB + 2) begin n_err++; $display("FAIL held_repress: got %0d want %0d", n_iv, 51 + DB + 2); end
      n_cmp++; if (first_player !== 2'd0) begin n_err++; $display("FAIL held_fp: got %0d want 0", first_player); end
      last_fp = 0; last_sw = int'(sw_all[7:0]); ptr_model = 1;
      do_ack();
      release_all();
   endtask

   task automatic test_random();
      int on[4], off[4];
      int n_iv, n_to, o_min, exp_iv, exp_to, exp_fp;
      bit [3:0] tied;
      bit aok, both;
      for (int r = 0; r < 12; r++) begin
         sw_all = $urandom;
         off = '{-1, -1, -1, -1};
         for (int i = 0; i < 4; i++)
            on[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 95));
         if (r == 0) on = '{-1, 82, -1, 82};
         o_min = 1000;
         for (int i = 0; i < 4; i++)
            if (on[i] >= 0 && on[i] < o_min) o_min = on[i];
         tied = '0;
         for (int i = 0; i < 4; i++) tied[i] = (on[i] == o_min);
         if (o_min + DB + 2 <= TMO) begin
            exp_iv = o_min + DB + 2; exp_to = -1; exp_fp = model_winner(tied, ptr_model);
         end else begin
            exp_iv = -1; exp_to = TMO; exp_fp = last_fp;
         end
         do_arm();
         run_round(on, off, TMO + 5, n_iv, n_to, aok);
         $display("random round %0d: on=%0d/%0d/%0d/%0d ptr=%0d -> valid %0d timeout %0d fp=%0d sw=%h",
                  r, on[0], on[1], on[2], on[3], ptr_model, n_iv, n_to, first_player, switch_value);
         n_cmp++; if (n_iv !== exp_iv || n_to !== exp_to) begin n_err++; $display("FAIL rand_event r%0d: got valid %0d timeout %0d want %0d/%0d", r, n_iv, n_to, exp_iv, exp_to); end
         n_cmp++; if (aok !== 1'b1) begin n_err++; $display("FAIL rand_armed r%0d: got %b want 1", r, aok); end
         n_cmp++; if (first_player !== 2'(exp_fp)) begin n_err++; $display("FAIL rand_fp r%0d: got %0d want %0d", r, first_player, exp_fp); end
         if (exp_iv >= 0) begin
            n_cmp++; if (switch_value !== sw_all[8*exp_fp +: 8]) begin n_err++; $display("FAIL rand_sw r%0d: got %h want %h", r, switch_value, sw_all[8*exp_fp +: 8]); end
            last_fp = exp_fp; last_sw = int'(sw_all[8*exp_fp +: 8]); ptr_model = (exp_fp + 1) % 4;
            both = 1'($urandom_range(0, 1));
            arm = both; ack = 1'b1;
            tick();
            arm = 1'b0; ack = 1'b0;
            n_cmp++; if (input_valid !== 1'b0 || armed !== 1'b0) begin n_err++; $display("FAIL rand_ack r%0d: got valid=%b armed=%b want 0/0", r, input_valid, armed); end
         end else begin
            n_cmp++; if (switch_value !== 8'(last_sw)) begin n_err++; $display("FAIL rand_hold_sw r%0d: got %h want %h", r, switch_value, 8'(last_sw)); end
            tick();
            n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rand_tmo_width r%0d: got %b want 0", r, timeout); end
         end
         release_all();
      end
   endtask

   task automatic test_reset_mid();
      int on[4], off[4];
      int n_iv, n_to;
      bit aok, seen;
      on = '{-1, -1, 1, -1};
      off = '{-1, -1, -1, -1};
      do_arm();
      run_round(on, off, 40, n_iv, n_to, aok);
      n_cmp++; if (first_player !== 2'd2 || input_valid !== 1'b1) begin n_err++; $display("FAIL midreset_setup: got fp=%0d valid=%b want 2/1", first_player, input_valid); end
      #2 reset = 1'b1;
      #1;
      $display("mid-round reset: armed=%b valid=%b fp=%0d sw=%h timeout=%b", armed, input_valid, first_player, switch_value, timeout);
      n_cmp++; if ({armed, input_valid, first_player, switch_value, timeout} !== 13'd0) begin n_err++; $display("FAIL midreset_outputs: got %b want all zero", {armed, input_valid, first_player, switch_value, timeout}); end
      btn = 4'b0000;
      #2 reset = 1'b0;
      tick();
      ptr_model = 0; last_fp = 0; last_sw = 0;
      repeat (4) tick();
      btn = 4'b0010;
      seen = 1'b0;
      for (int s = 0; s < 40; s++) begin
         tick();
         if (input_valid !== 1'b0 || armed !== 1'b0 || timeout !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_unarmed_press: got activity=%b want 0", seen); end
      release_all();
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_basic();
      test_glitch();
      test_timeout();
      test_held();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Sequences the quiz-round player input path: synchronises and debounces four player buttons, arbitrates the first press, and snapshots that player's 8 switches.
- Holds the result until the CPU acknowledges it.
- Replaces the asynchronous multi-edge first-player latch; drives the player-select and input-valid controls seen by the CPU-side switch input.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change a debounced button level (>=1).
- TIMEOUT_CYCLES, 0, clocks allowed in ARMED before the round times out; 0 disables the timeout.
- CNT_W, 24, width of the timeout counter (TIMEOUT_CYCLES < 2^CNT_W).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn  input  4  raw player buttons, bit i = player i, asynchronous.
- sw_all  input  32  raw player switches, bits [8i+7:8i] = player i, asynchronous.
- arm  input  1  single-cycle pulse: open a round.
- ack  input  1  single-cycle pulse: CPU consumed the result.
- armed  output  1  high while in ARMED.
- input_valid  output  1  high while in CAPTURED (the playerInputFlag function).
- first_player  output  2  winning player index.
- switch_value  output  8  captured switches of the winner.
- timeout  output  1  one-cycle pulse when a round expires.

Behaviour:
- Reset (async, immediate): state IDLE; armed=0, input_valid=0, first_player=0, switch_value=0, timeout=0. Priority pointer=0; debounced levels=0; all counters=0; synchronisers=0.
- Synchronisation: btn and sw_all each pass through a 2-FF synchroniser.
- Debounce, per player:
  - The counter increments on each edge where the synchronised bit differs from the debounced level, and clears when they match.
  - On the edge where the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - The press event is the rising edge of the debounced level, one cycle wide.
  - Debounce runs in every state.
- Latency: if btn is first sampled high at edge E0 and stays high, the press event occurs at edge E0+DEBOUNCE_CYCLES+1 and input_valid rises at edge E0+DEBOUNCE_CYCLES+2.
- States:
  - IDLE: arm -> ARMED, timeout counter cleared. Press events are ignored, not queued.
  - ARMED:
    - Any press event -> CAPTURED.
    - Else, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 -> IDLE with timeout=1 for one cycle.
    - Else the counter increments.
    - arm is ignored.
  - CAPTURED: ack -> IDLE; input_valid falls at that edge. arm and press events are ignored.
- Capture (ARMED->CAPTURED edge):
  - first_player = winner.
  - switch_value = synchronised sw_all slice of the winner at that edge.
  - Priority pointer = (winner+1) mod 4.
- Arbitration: among simultaneous press events, the winner is the first set bit scanning from the priority pointer upward, wrapping 3->0.
- Held buttons: a button already debounced-high when arm arrives produces no event; the player must release and re-press.
- Simultaneous events:
  - Press and timeout on the same edge: the press wins; no timeout pulse.
  - arm and ack together in CAPTURED: ack is honoured, arm is dropped.
- first_player and switch_value hold their values through IDLE until the next capture.
- Reset mid-round: the round is abandoned; no timeout pulse.

Test Plan:
- Reset, arm, btn[0] high held 30 cycles with DEBOUNCE_CYCLES=16, sw_all[7:0]=0xA5 -> input_valid rises at E0+18; first_player=0, switch_value=0xA5; ack -> input_valid=0 next edge.
- btn[2] glitch high for 10 cycles while ARMED (DEBOUNCE_CYCLES=16) -> no capture; armed stays 1.
- Pointer=0, btn[1] and btn[3] rise on the same edge -> first_player=1. Next round, same stimulus (pointer=2) -> first_player=3.
- btn[0] held before arm, then arm -> no capture. Release >=16 cycles, then re-press -> capture with first_player=0.
- TIMEOUT_CYCLES=100, arm, no presses -> timeout pulse exactly 100 cycles after the arm edge; state IDLE; input_valid=0.
- reset asserted while CAPTURED with first_player=2 -> all outputs 0 immediately. A press after deassert and without arm -> ignored.
